instruction_fetch_unit: RTL

Instruction fetch stage for the MIPS datapath. Owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. Honours stall, flush and PC redirects (branch/jump) from the hazard and branch logic. Exports a retired-fetch counter for lab performance measurements.

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_if_id_register.sv | 60 ++++++
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared constants and types for the instruction fetch stage
//
// Purpose: default reset PC, the NOP encoding injected on reset/flush, the
// instruction width, the sequential PC increment and the IF/ID record type.
// Ports: none (package).
package instruction_fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] IFU_RESET_PC     = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] IFU_NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
    logic               valid;
  } if_id_t;

  // Word-align a byte address; the PC never holds a misaligned value.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// rtl/instruction_fetch_unit_if_id_register.sv - IF/ID pipeline register with stall and flush
//
// Purpose: holds the fetched instruction, its PC+4 and a valid bit between
// the fetch and decode stages. Flush beats Stall; a flush keeps PCPlus4_ID.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Stall, Flush        hold contents / squash to NOP_WORD with Valid_ID=0
//   InstrIn, PCPlus4In  values captured on a normal edge
//   Instruction_ID, PCPlus4_ID, Valid_ID  registered outputs
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = IFU_NOP_WORD
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic [31:0]        PCPlus4In,
  output logic [INSTR_W-1:0] Instruction_ID,
  output logic [31:0]        PCPlus4_ID,
  output logic               Valid_ID
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (Flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (!Stall) begin
      instr_d    = InstrIn;
      pc_plus4_d = PCPlus4In;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign Instruction_ID = instr_q;
  assign PCPlus4_ID     = pc_plus4_q;
  assign Valid_ID       = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, next-PC select, IF/ID, fetch counter
//
// Purpose: owns the PC, presents it to the combinational instruction memory,
// captures the returned word into IF/ID and counts captured instructions.
// Ports:
//   Clk, Reset                     clock, asynchronous active-high reset
//   InstrAddress (out)             fetch byte address, registered PC only
//   InstrData (in)                 memory word for InstrAddress
//   Stall, Flush                   hazard hold / IF/ID squash
//   RedirectValid, RedirectTarget  branch/jump PC load (beats Stall)
//   PC_IF (out)                    current PC
//   Instruction_ID, PCPlus4_ID, Valid_ID (out)  IF/ID contents
//   FetchCount (out)               captures since reset, wraps
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_WORD = IFU_NOP_WORD
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [31:0]        InstrAddress,
  input  logic [INSTR_W-1:0] InstrData,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               RedirectValid,
  input  logic [31:0]        RedirectTarget,
  output logic [31:0]        PC_IF,
  output logic [INSTR_W-1:0] Instruction_ID,
  output logic [31:0]        PCPlus4_ID,
  output logic               Valid_ID,
  output logic [31:0]        FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  logic        capture;

  // Wraps modulo 2^32 with no carry-out.
  assign pc_plus4 = pc_q + PC_INCR;
  assign capture  = !Flush && !Stall;

  // Redirect beats Stall so a taken branch is never lost behind a hazard hold.
  always_comb begin
    pc_d = pc_plus4;
    if (RedirectValid) begin
      pc_d = word_align(RedirectTarget);
    end else if (Stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Flush          (Flush),
    .InstrIn        (InstrData),
    .PCPlus4In      (pc_plus4),
    .Instruction_ID (Instruction_ID),
    .PCPlus4_ID     (PCPlus4_ID),
    .Valid_ID       (Valid_ID)
  );

  assign InstrAddress = pc_q;
  assign PC_IF        = pc_q;
  assign FetchCount   = fetch_count_q;

endmodule
